mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the maximum number of consecutive LSU grants issued while a fetch request waits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 if_valid  input  1  fetch read request; held until if_ready.
REQ-005 if_addr  input  32 (addr_t)  fetch address.
REQ-006 if_ready  output  1  fetch transaction complete.
REQ-007 if_rdata  output  32 (data_t)  fetch read data.
REQ-008 ls_valid  input  1  LSU request; held until ls_ready.
REQ-009 ls_addr  input  32 (addr_t)  LSU address.
REQ-010 ls_wdata  input  32 (data_t)  LSU store data.
REQ-011 ls_byte_en  input  4 (byte_en_t)  store byte enable; 4'b0000 means load.
REQ-012 ls_ready  output  1  LSU transaction complete.
REQ-013 ls_rdata  output  32 (data_t)  LSU load data.
REQ-014 mem_valid  output  1  request to shared memory port.
REQ-015 mem_addr, mem_wdata, mem_byte_en  output  32/32/4  registered request fields.
REQ-016 mem_ready  input  1  memory completes the current request.
REQ-017 mem_rdata  input  32  memory read data, valid with mem_ready.

Function
REQ-018 FSM states: IDLE, BUSY_IF, BUSY_LS; only one transaction outstanding.
REQ-019 In IDLE with only one valid: grant that requester; with neither: stay IDLE.
REQ-020 In IDLE with both valid: grant LSU unless streak == STARVE_LIMIT, in which case grant fetch.
REQ-021 On a grant, the winner's fields are latched into mem_addr/mem_wdata/mem_byte_en and mem_valid = 1 from the next cycle.
REQ-022 Fetch grants drive mem_byte_en = 4'b0000 and mem_wdata = 0.
REQ-023 mem_valid and all mem_* fields are held stable while in BUSY_x until mem_ready.
REQ-024 In BUSY_x, on mem_ready = 1: x_ready = 1 combinationally in the same cycle, x_rdata = mem_rdata, and the next state is IDLE.
REQ-025 x_ready = 0 and x_rdata = 0 whenever not (state == BUSY_x and mem_ready).
REQ-026 Latency: request seen in IDLE at cycle t gives mem_valid at t+1 and, with zero-wait memory, x_ready at t+1; minimum 2 cycles per transaction, one IDLE cycle between transactions.
REQ-027 Streak counter increments (saturating at STARVE_LIMIT) on each LSU grant made while if_valid = 1; it clears on any fetch grant or any IDLE cycle with if_valid = 0.
REQ-028 A requester dropping valid mid-transaction does not abort it: the transaction completes and the ready pulse is still issued.
REQ-029 mem_ready while in IDLE is ignored and produces no ready pulse.
REQ-030 Inputs sampled in BUSY_x have no effect until the next IDLE cycle.

Reset
REQ-031 While rst = 1: state = IDLE, mem_valid = 0, mem_addr/mem_wdata/mem_byte_en = 0, streak = 0, both ready outputs = 0.
REQ-032 A reset asserted mid-transaction abandons the transaction: mem_valid = 0 in the cycle after the reset edge and no ready pulse is issued.

Structure
REQ-033 addr_t, data_t, and byte_en_t come from type_pkg; the state enum arb_state_t is added to type_pkg.
REQ-034 The block is a single module with no sub-module; the grant decision is an always_comb block feeding a registered FSM.
REQ-035 Streak counter width is $clog2(STARVE_LIMIT+1).

Verification
REQ-036 Fetch only, if_addr = 0x100, memory answers in 1 cycle: mem_valid at t+1 with mem_byte_en = 0000; if_ready at t+1; if_rdata = mem_rdata.
REQ-037 LSU store, ls_addr = 0x2000, ls_wdata = 0xDEADBEEF, ls_byte_en = 0011, memory stalls 3 cycles: mem_* held constant for 4 cycles; ls_ready pulses exactly once.
REQ-038 Both requesters continuously valid, STARVE_LIMIT = 4: grant order is LS, LS, LS, LS, IF, then repeats.
REQ-039 rst asserted while in BUSY_LS with memory stalled: next cycle mem_valid = 0 and state = IDLE; no ls_ready pulse.
REQ-040 mem_ready pulsed in IDLE: no ready output; if if_valid deasserts during BUSY_IF: the transaction still completes and if_ready still pulses.

Source files
------------

// File: rtl/type_pkg.sv
// Shared bus types for the core memory subsystem, including the
// state encoding for the single-port memory arbiter.
package type_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  byte_en_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one memory port.
// LSU has priority, but fetch is granted after STARVE_LIMIT consecutive LSU wins.
module mem_arbiter
  import type_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     if_valid,
  input  addr_t    if_addr,
  output logic     if_ready,
  output data_t    if_rdata,
  input  logic     ls_valid,
  input  addr_t    ls_addr,
  input  data_t    ls_wdata,
  input  byte_en_t ls_byte_en,
  output logic     ls_ready,
  output data_t    ls_rdata,
  output logic     mem_valid,
  output addr_t    mem_addr,
  output data_t    mem_wdata,
  output byte_en_t mem_byte_en,
  input  logic     mem_ready,
  input  data_t    mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_V = SW'(STARVE_LIMIT);

  arb_state_t     state, state_nxt;
  logic [SW-1:0]  streak, streak_nxt;
  addr_t          addr_nxt;
  data_t          wdata_nxt;
  byte_en_t       be_nxt;
  logic           grant_if, grant_ls;

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    addr_nxt   = mem_addr;
    wdata_nxt  = mem_wdata;
    be_nxt     = mem_byte_en;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;
    case (state)
      IDLE: begin
        grant_if = if_valid && (!ls_valid || streak == LIMIT_V);
        grant_ls = ls_valid && !grant_if;
        if (grant_if) begin
          state_nxt  = BUSY_IF;
          addr_nxt   = if_addr;
          wdata_nxt  = '0;
          be_nxt     = '0;
          streak_nxt = '0;
        end else if (grant_ls) begin
          state_nxt = BUSY_LS;
          addr_nxt  = ls_addr;
          wdata_nxt = ls_wdata;
          be_nxt    = ls_byte_en;
          // Only LSU wins that make a waiting fetch wait longer count.
          if (!if_valid)
            streak_nxt = '0;
          else if (streak != LIMIT_V)
            streak_nxt = streak + SW'(1);
        end else begin
          streak_nxt = '0;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      streak      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_byte_en <= '0;
    end else begin
      state       <= state_nxt;
      streak      <= streak_nxt;
      mem_addr    <= addr_nxt;
      mem_wdata   <= wdata_nxt;
      mem_byte_en <= be_nxt;
    end
  end

  // Reset gates the outputs so an abandoned transaction never reports completion.
  assign mem_valid = (state != IDLE) && !rst;
  assign if_ready  = !rst && (state == BUSY_IF) && mem_ready;
  assign ls_ready  = !rst && (state == BUSY_LS) && mem_ready;
  assign if_rdata  = if_ready ? mem_rdata : '0;
  assign ls_rdata  = ls_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;
  import type_pkg::*;

  localparam int LIMIT = 4;

  logic     clk = 1'b0;
  logic     rst;
  logic     if_valid, ls_valid, mem_ready;
  addr_t    if_addr, ls_addr, mem_addr;
  data_t    ls_wdata, mem_wdata, mem_rdata, if_rdata, ls_rdata;
  byte_en_t ls_byte_en, mem_byte_en;
  logic     if_ready, ls_ready, mem_valid;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_byte_en(ls_byte_en),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: who owns the port, the request it carries, and how many
  // LSU wins in a row a waiting fetch has had to sit through.
  int          m_owner = 0;   // 0 none, 1 fetch, 2 lsu
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be    = '0;
  int          m_streak = 0;

  logic        if_seen = 1'b0, ls_seen = 1'b0, prev_mv = 1'b0;
  int          ls_pulses = 0;
  bit          rec = 1'b0;
  logic [31:0] grants[$];

  always @(negedge clk) begin
    logic e_if, e_ls;
    int   pick;
    e_if = !rst && m_owner == 1 && mem_ready;
    e_ls = !rst && m_owner == 2 && mem_ready;
    check_eq("mem_valid", 64'(mem_valid), 64'(m_owner != 0 && !rst));
    check_eq("mem_addr", 64'(mem_addr), 64'(m_addr));
    check_eq("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    check_eq("mem_byte_en", 64'(mem_byte_en), 64'(m_be));
    check_eq("if_ready", 64'(if_ready), 64'(e_if));
    check_eq("if_rdata", 64'(if_rdata), e_if ? 64'(mem_rdata) : 64'd0);
    check_eq("ls_ready", 64'(ls_ready), 64'(e_ls));
    check_eq("ls_rdata", 64'(ls_rdata), e_ls ? 64'(mem_rdata) : 64'd0);

    if_seen = if_ready;
    ls_seen = ls_ready;
    if (ls_ready) ls_pulses++;
    if (rec && mem_valid && !prev_mv) grants.push_back(mem_addr);
    prev_mv = mem_valid;

    if (rst) begin
      m_owner = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_streak = 0;
    end else if (m_owner != 0) begin
      if (mem_ready) m_owner = 0;
    end else begin
      pick = 0;
      if (if_valid && ls_valid) pick = (m_streak == LIMIT) ? 1 : 2;
      else if (if_valid)        pick = 1;
      else if (ls_valid)        pick = 2;
      if (pick == 1) begin
        m_owner = 1; m_addr = if_addr; m_wdata = '0; m_be = '0; m_streak = 0;
      end else if (pick == 2) begin
        m_owner = 2; m_addr = ls_addr; m_wdata = ls_wdata; m_be = ls_byte_en;
        if (if_valid) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
        else          m_streak = 0;
      end else if (!if_valid) begin
        m_streak = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    rst = 1'b1; if_valid = 0; ls_valid = 0; mem_ready = 0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_byte_en = '0; mem_rdata = '0;
    repeat (3) cyc();
    @(negedge clk);
    check_eq("reset_mem_valid", 64'(mem_valid), 64'd0);
    check_eq("reset_mem_addr", 64'(mem_addr), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Single fetch against a zero-wait memory.
    if_valid = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'hCAFE0001;
    cyc();
    @(negedge clk);
    check_eq("fetch_mem_valid", 64'(mem_valid), 64'd1);
    check_eq("fetch_byte_en", 64'(mem_byte_en), 64'd0);
    check_eq("fetch_addr", 64'(mem_addr), 64'h100);
    check_eq("fetch_ready", 64'(if_ready), 64'd1);
    check_eq("fetch_rdata", 64'(if_rdata), 64'hCAFE0001);
    cyc();
    if_valid = 0; mem_ready = 0;
    cyc();

    // Store held through a 3-cycle memory stall.
    p0 = ls_pulses;
    ls_valid = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; ls_byte_en = 4'b0011;
    cyc();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      @(negedge clk);
      check_eq("store_hold_addr", 64'(mem_addr), 64'h2000);
      check_eq("store_hold_wdata", 64'(mem_wdata), 64'hDEADBEEF);
      check_eq("store_hold_be", 64'(mem_byte_en), 64'h3);
      check_eq("store_hold_valid", 64'(mem_valid), 64'd1);
      if (i < 3) cyc();
    end
    cyc();
    ls_valid = 0; mem_ready = 0; ls_byte_en = '0;
    cyc(); cyc();
    check_eq("store_ready_pulses", 64'(ls_pulses - p0), 64'd1);

    // Both requesters continuously valid: starvation guard ordering.
    grants.delete();
    rec = 1;
    if_valid = 1; if_addr = 32'h100; ls_valid = 1; ls_addr = 32'h2000; mem_ready = 1;
    repeat (20) cyc();
    if_valid = 0; ls_valid = 0; rec = 0;
    cyc();
    check_eq("grant_count", 64'(grants.size()), 64'd10);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      check_eq($sformatf("grant_%0d", i), 64'(grants[i]),
               (i % 5 == 4) ? 64'h100 : 64'h2000);
    mem_ready = 0;
    cyc();

    // Reset in the middle of a stalled load.
    ls_valid = 1; ls_addr = 32'h3000;
    cyc(); cyc();
    p0 = ls_pulses;
    rst = 1;
    cyc();
    rst = 0; ls_valid = 0;
    @(negedge clk);
    check_eq("rst_abort_valid", 64'(mem_valid), 64'd0);
    cyc(); cyc();
    check_eq("rst_abort_pulses", 64'(ls_pulses - p0), 64'd0);

    // Stray mem_ready in IDLE, then a fetch whose valid drops mid-transaction.
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("idle_if_ready", 64'(if_ready), 64'd0);
      check_eq("idle_ls_ready", 64'(ls_ready), 64'd0);
      cyc();
    end
    mem_ready = 0; if_valid = 1; if_addr = 32'h400;
    cyc();
    if_valid = 0;
    cyc(); cyc();
    mem_ready = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    check_eq("drop_if_ready", 64'(if_ready), 64'd1);
    check_eq("drop_if_rdata", 64'(if_rdata), 64'h12345678);
    cyc();
    mem_ready = 0;
    cyc();

    // Random traffic with protocol-respecting requesters.
    for (int c = 0; c < 3000; c++) begin
      if (!if_valid) begin
        if ($urandom_range(2) == 0) begin if_valid = 1; if_addr = $urandom; end
      end else if (if_seen) begin
        if_valid = $urandom_range(1); if_addr = $urandom;
      end else if ($urandom_range(29) == 0) begin
        if_valid = 0;
      end
      if (!ls_valid) begin
        if ($urandom_range(2) == 0) begin
          ls_valid = 1; ls_addr = $urandom; ls_wdata = $urandom; ls_byte_en = 4'($urandom);
        end
      end else if (ls_seen) begin
        ls_valid = $urandom_range(1);
        ls_addr = $urandom; ls_wdata = $urandom; ls_byte_en = 4'($urandom);
      end else if ($urandom_range(29) == 0) begin
        ls_valid = 0;
      end
      mem_ready = $urandom_range(1);
      mem_rdata = $urandom;
      rst = ($urandom_range(199) == 0);
      cyc();
    end
    rst = 0; if_valid = 0; ls_valid = 0; mem_ready = 0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
